// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned MIN_WIDTH = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout set when a borrow is needed.
module fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_SATURATE_EN to clamp diff to zero on a final borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < MIN_WIDTH) begin : g_width_chk
    $error("serial_subtractor: WIDTH must be >= MIN_WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               fs_diff, fs_bout;

  fullsubtractor u_fs (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Bin (brw_q),
    .Diff(fs_diff),
    .Bout(fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = WIDTH'({fs_diff, res_q} >> 1);
        brw_d = fs_bout;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the completed result on the DONE-entry edge.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          bout_d  = fs_bout;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
          diff_d  = fs_bout ? '0 : res_d;
`else
          diff_d  = res_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
  localparam logic [7:0] BORROW_DIFF = 8'h00;
`else
  localparam logic [7:0] BORROW_DIFF = 8'hFF;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done; returns cycles waited and busy cycles seen.
  task automatic wait_done(output int cyc, output int busy_n, output bit seen);
    cyc = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input string tag);
    int cyc, busy_n;
    bit seen;
    @(posedge clk); #1;
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, busy_n, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int cyc, busy_n, cnt;
    bit seen;

    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, BORROW_DIFF, 1'b1, "underflow");
    do_op(8'hFF, 8'hFF, 1'b1, BORROW_DIFF, 1'b1, "ff_ff_bin");
    do_op(8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, "c8_64_bin");

    // Start re-pulse during SHIFT with different operands is ignored.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(cyc, busy_n, seen);
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_diff", 32'(diff), 32'h37);
    chk("ignore_bout", 32'(bout), 32'd0);

    // Reset in the 4th SHIFT cycle aborts immediately with no strobe.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h23; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("rst_no_activity", 32'(cnt), 32'd0);
    do_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "after_rst");

    // Back-to-back: start held high through DONE with new operands.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    wait_done(cyc, busy_n, seen);
    chk("b2b_first_seen", 32'(seen), 32'd1);
    chk("b2b_first_diff", 32'(diff), 32'h37);
    a = 8'h80; b = 8'h01;
    @(negedge clk);
    chk("b2b_busy_rerise", 32'(busy), 32'd1);
    chk("b2b_done_drop", 32'(done), 32'd0);
    start = 1'b0;
    wait_done(cyc, busy_n, seen);
    chk("b2b_second_seen", 32'(seen), 32'd1);
    chk("b2b_spacing", 32'(cyc + 1), 32'd9);
    chk("b2b_second_diff", 32'(diff), 32'h7F);
    chk("b2b_second_bout", 32'(bout), 32'd0);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
